// File: rtl/led_pattern_capture_if.sv
// Capture-side bundle for led_pattern_capture.
// master: stream source / read-back consumer (arm, dot, dot_vld, rd_addr out;
//         rd_data and the status lines in).
// slave : the capture block itself.
interface led_pattern_capture_if #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned AW    = 5
);
  logic             arm;
  logic [WIDTH-1:0] dot;
  logic             dot_vld;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             busy;
  logic             done;
  logic             err;
  logic [AW:0]      col_cnt;

  modport master (
    output arm, dot, dot_vld, rd_addr,
    input  rd_data, busy, done, err, col_cnt
  );

  modport slave (
    input  arm, dot, dot_vld, rd_addr,
    output rd_data, busy, done, err, col_cnt
  );
endinterface

// File: rtl/led_pattern_capture.sv
// Receive-side LED column recorder: waits for a frame after arm, stores
// DEPTH columns of WIDTH bits into a pattern memory, aborts a frame whose
// stream goes idle for more than GAP_MAX cycles, and exposes the memory on a
// registered read port.
// Ports:
//   clk    system clock, all logic on posedge
//   rst_n  asynchronous active-low reset
//   bus    slave side of led_pattern_capture_if
//            arm/dot/dot_vld : frame control and column stream
//            rd_addr/rd_data : read port, 1-cycle latency, read-before-write
//            busy/done/err   : frame status (done/err held until next arm)
//            col_cnt         : columns written in the current/last frame
module led_pattern_capture #(
  parameter int unsigned WIDTH   = 5,
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned GAP_MAX = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  led_pattern_capture_if.slave    bus
);

  localparam int unsigned CW = AW + 1;
  localparam int unsigned GW = $clog2(GAP_MAX + 1) + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    col_cnt_q;
  logic [GW-1:0]    gap_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [WIDTH-1:0] rd_data_q;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             wr_en_c;
  logic [AW-1:0]    wr_addr_c;

  // Memory write strobe: any valid column while waiting for or inside a frame.
  // The low bits of col_cnt double as the write pointer, so each frame starts
  // at address 0 and can never wrap before the frame is complete.
  always_comb begin
    wr_en_c   = 1'b0;
    wr_addr_c = col_cnt_q[AW-1:0];
    case (state_q)
      S_ARMED: begin
        wr_en_c   = bus.dot_vld;
        wr_addr_c = '0;
      end
      S_CAPTURE: begin
        wr_en_c   = bus.dot_vld;
      end
      default: begin
        wr_en_c   = 1'b0;
      end
    endcase
  end

  // Frame control FSM with registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      col_cnt_q <= '0;
      gap_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          // A dot_vld coinciding with arm is dropped: the first column is
          // only accepted from ARMED.
          if (bus.arm) begin
            state_q   <= S_ARMED;
            col_cnt_q <= '0;
            gap_q     <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
          end
        end

        S_ARMED: begin
          // No timeout here; the gap limit only applies once a frame started.
          if (bus.dot_vld) begin
            state_q   <= S_CAPTURE;
            col_cnt_q <= CW'(1);
            gap_q     <= '0;
          end
        end

        S_CAPTURE: begin
          if (bus.dot_vld) begin
            col_cnt_q <= col_cnt_q + CW'(1);
            gap_q     <= '0;
            if (col_cnt_q == CW'(DEPTH - 1)) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else if (gap_q == GW'(GAP_MAX)) begin
            // One more idle cycle would exceed the limit: abort, keep the
            // partial count for diagnosis.
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
            gap_q   <= '0;
          end else begin
            gap_q   <= gap_q + GW'(1);
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Pattern memory: contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_q[wr_addr_c] <= bus.dot;
    end
  end

  // Registered read; a same-cycle write to rd_addr is seen one read later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[bus.rd_addr];
    end
  end

  assign bus.rd_data = rd_data_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.col_cnt = col_cnt_q;

endmodule
